// File: rtl/mysystem_vga_timing.sv
// VGA raster timing: pixel divider, h/v counters, and registered sync/blank flags.
// Counters are visible directly; flags lag them by one clk.
module mysystem_vga_timing #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic       pix_en,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       vblank,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DW-1:0] div;
  logic [9:0]    h_count;
  logic [9:0]    v_count;
  logic          div_last;
  logic          h_last;
  logic          hs_act;
  logic          vs_act;
  logic          vis;
  logic          vb_now;

  assign div_last = (div == DIV_LAST);
  // Gated by reset so the strobe is idle while reset is held.
  assign pix_en   = reset_n & enable & div_last;
  assign h_last   = (h_count >= H_LAST);

  assign hs_act = (h_count >= HS_BEG) && (h_count <= HS_END);
  assign vs_act = (v_count >= VS_BEG) && (v_count <= VS_END);
  assign vis    = (h_count < H_VIS_L) && (v_count < V_VIS_L);
  assign vb_now = (v_count >= V_VIS_L);

  assign pixel_x = h_count;
  assign pixel_y = v_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (!enable || div_last) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Wraps use >= so no enable/reset sequence can leave a counter out of range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (!enable) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_en) begin
      h_count <= h_last ? 10'd0 : h_count + 10'd1;
      if (h_last) begin
        v_count <= (v_count >= V_LAST) ? 10'd0 : v_count + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      video_on   <= 1'b0;
      vblank     <= 1'b0;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      video_on   <= 1'b0;
      vblank     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hsync_n    <= ~hs_act;
      vsync_n    <= ~vs_act;
      video_on   <= vis;
      vblank     <= vb_now;
      frame_tick <= vb_now & ~vblank;
    end
  end

endmodule
